bus_mem_slave: RTL and testbench
================================

# bus_mem_slave

Parametrised memory-backed slave for the system bus, the next generation of the fixed 4 KiB / 8-bit / 3-wait-state slave. Address width, data width, memory depth and wait-state latency are all configurable. It adds an out-of-range error response, and it accesses memory only at the response edge, so `rdata` is defined exactly when `ready` is high. It sits behind the address decoder, which drives `sl`, and answers the bus master with a one-cycle `ready` pulse per transaction.

## Interface
- `ADDR_W`, 16: bus address width.
- `DATA_W`, 8: data width.
- `MEM_DEPTH`, 4096: number of words; any value 2..2**ADDR_W; need not be a power of two.
- `LATENCY`, 3: clock edges from accept to `ready` rise; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sl` in 1: slave select from the decoder.
- `valid` in 1: master request strobe.
- `mode` in 1: 1 = write, 0 = read.
- `addr` in ADDR_W: word address.
- `wdata` in DATA_W: write data.
- `rdata` out DATA_W: read data; valid while `ready`=1 and `err`=0.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: high with `ready` when the address was out of range.

## Operation
- FSM states:
  - IDLE: on `sl && valid`, latch `addr`, `wdata`, `mode`; set `cnt`=1; go to WAIT. Otherwise stay.
  - WAIT: if `cnt`==LATENCY, go to RESP and set `ready`=1. Otherwise `cnt`+1.
  - RESP: set `ready`=0 and `err`=0; go to IDLE.
- Range check: `oor` = (latched addr >= MEM_DEPTH), using a full ADDR_W comparison. Compute it at accept and register it.
- The memory access happens on the WAIT->RESP edge, the same edge `ready` rises:
  - Write, in range: mem[addr] <= wdata.
  - Read, in range: `rdata` <= mem[addr].
  - Out of range: no memory write, `rdata` unchanged, `err` <= 1.
- `rdata` holds its last read value until the next in-range read. Writes never change `rdata`.
- Inputs are ignored outside IDLE. `valid`/`sl` asserted during WAIT or RESP is neither queued nor accepted.
- The master may drop `valid` after the accept edge.
- Memory index = addr[$clog2(MEM_DEPTH)-1:0]. It is used only when in range.
- `cnt` width = $clog2(LATENCY+1).

## Timing
- Reset (async assert, any state) gives:
  - state=IDLE, `ready`=0, `err`=0, `rdata`=0, `cnt`=0.
  - Latched registers cleared.
  - Memory contents not reset and not modified.
- A reset mid-transaction aborts it: no write occurs and no `ready` pulse is issued.
- Deassertion takes effect at the first rising edge with `rst_n`=1.
- Accept edge E0 (IDLE, `sl && valid` sampled high).
- `ready` rises at edge E0+LATENCY and falls at E0+LATENCY+1. It is exactly one cycle wide.
- With LATENCY=1, `ready` rises at the edge after accept.
- Earliest next accept: edge E0+LATENCY+2, because IDLE samples after RESP.
- Throughput: one transaction per LATENCY+2 cycles.
- `err` is only ever high while `ready` is high.

## Structure
- Shared package `bus_pkg`:
  - State typedef `bus_slv_state_t` {IDLE, WAIT, RESP}.
  - `MODE_READ`=1'b0, `MODE_WRITE`=1'b1.
  - Reused by other bus slaves and the master.
- Sub-module `bus_sp_ram`:
  - Single-port synchronous RAM, parameters DATA_W and MEM_DEPTH.
  - Ports `clk`, `we`, `re`, `idx`, `wd`, `rd`; no reset.
  - The FSM pulses `we`/`re` for one cycle on the WAIT->RESP edge.
  - `bus_mem_slave` owns the FSM, range check and output registers.

## Test plan
- Default params: write 0xA5 to 0x0010, then read 0x0010 -> `ready` rises exactly 3 edges after each accept; read returns `rdata`=0xA5 with `err`=0.
- Out-of-range, MEM_DEPTH=3000: write 0x55 to 3000, then read 2999 -> write gives `err`=1 with `ready`; the word at index 3000 mod 4096 is untouched; read `rdata` = previously written value.
- LATENCY=1, DATA_W=16: back-to-back requests with `valid` held high -> accepts every 3 cycles; `valid` during WAIT/RESP is ignored; 0xBEEF round-trips.
- Reset mid-WAIT of a write to 0x0020 (preloaded 0x11): assert `rst_n`=0 asynchronously -> outputs 0 immediately; no `ready`; read after reset returns 0x11.
- Read an out-of-range address after a read of 0x33 -> `err`=1, `rdata` stays 0x33; a subsequent in-range write leaves `rdata` at 0x33.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state and mode encodings for system bus masters and slaves
package bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_slv_state_t;
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;
endpackage

// File: rtl/bus_mem_slave_if.sv
// bus_mem_slave_if: system bus request/response signals with master and slave views
interface bus_mem_slave_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              sl;
    logic              valid;
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;
    modport master (output sl, valid, mode, addr, wdata, input rdata, ready, err);
    modport slave  (input sl, valid, mode, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/bus_sp_ram.sv
// bus_sp_ram: single-port synchronous RAM, read data held until the next read
module bus_sp_ram #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4096,
    localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // write and read ports share one index; rd only moves on a read strobe
    always_ff @(posedge clk) begin
        if (we) r_mem[idx] <= wd;
        if (re) rd <= r_mem[idx];
    end
endmodule

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: memory-backed bus slave with fixed wait-state latency and range error
module bus_mem_slave import bus_pkg::*; #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4096,
    parameter int LATENCY   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_mem_slave_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    bus_slv_state_t    r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mode, r_oor, r_ready, r_err, r_have_rd;
    logic              w_accept, w_done, w_oor, w_we, w_re;
    logic [DATA_W-1:0] w_ram_rd;

    assign w_accept = (r_state == IDLE) && bus.sl && bus.valid;
    assign w_done   = (r_state == WAIT) && (r_cnt == CNT_W'(LATENCY));
    // one extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly
    assign w_oor    = (ADDR_W+1)'(bus.addr) >= (ADDR_W+1)'(MEM_DEPTH);
    assign w_we     = w_done && !r_oor && (r_mode == MODE_WRITE);
    assign w_re     = w_done && !r_oor && (r_mode == MODE_READ);

    // next state and wait counter
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state_nx = WAIT;
                w_cnt_nx   = CNT_W'(1);
            end
            WAIT: if (w_done) w_state_nx = RESP;
                  else        w_cnt_nx   = CNT_W'(r_cnt + 1'b1);
            RESP: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // state, request latches and response flags; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_mode    <= MODE_READ;
            r_oor     <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_have_rd <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_idx   <= bus.addr[IDX_W-1:0];
                r_wdata <= bus.wdata;
                r_mode  <= bus.mode;
                r_oor   <= w_oor;
            end
            r_ready <= w_done;
            r_err   <= w_done && r_oor;
            if (w_re) r_have_rd <= 1'b1;
        end
    end

    bus_sp_ram #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_ram (
        .clk (clk),
        .we  (w_we),
        .re  (w_re),
        .idx (r_idx),
        .wd  (r_wdata),
        .rd  (w_ram_rd)
    );

    // RAM output is unreset, so report zero until the first in-range read lands
    assign bus.rdata = r_have_rd ? w_ram_rd : '0;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: directed checks of a default slave and a 3000-word, 16-bit, latency-1 slave
module tb_bus_mem_slave;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_mem_slave_if #(.ADDR_W(16), .DATA_W(8))  b0 ();
    bus_mem_slave_if #(.ADDR_W(16), .DATA_W(16)) b1 ();

    bus_mem_slave u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    bus_mem_slave #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(3000), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic v, input logic m,
                         input logic [15:0] a, input logic [15:0] wd);
        if (d == 0) begin
            b0.sl = s; b0.valid = v; b0.mode = m; b0.addr = a; b0.wdata = wd[7:0];
        end else begin
            b1.sl = s; b1.valid = v; b1.mode = m; b1.addr = a; b1.wdata = wd;
        end
    endtask

    task automatic sample(input int d, output logic rdy, output logic er, output logic [15:0] rd);
        if (d == 0) begin
            rdy = b0.ready; er = b0.err; rd = {8'h00, b0.rdata};
        end else begin
            rdy = b1.ready; er = b1.err; rd = b1.rdata;
        end
    endtask

    // one transaction: valid for the accept edge only, then measure latency and response
    task automatic xact(input string tag, input int d, input logic m, input logic [15:0] a,
                        input logic [15:0] wd, input logic exp_err, input logic [15:0] exp_rd);
        int          n;
        logic        rdy, er;
        logic [15:0] rd;
        @(negedge clk);
        drive(d, 1'b1, 1'b1, m, a, wd);
        @(posedge clk);
        #1 drive(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            sample(d, rdy, er, rd);
        end while (!rdy && n < 20);
        chk({tag, ".lat"}, n, (d == 0) ? 3 : 1);
        chk({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
        chk({tag, ".rdata"}, {16'b0, rd}, {16'b0, exp_rd});
        @(posedge clk);
        #1 sample(d, rdy, er, rd);
        chk({tag, ".rdy_fall"}, {31'b0, rdy}, 32'd0);
        chk({tag, ".err_fall"}, {31'b0, er}, 32'd0);
    endtask

    initial begin
        logic        rdy, er, seen;
        logic [15:0] rd;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        sample(0, rdy, er, rd);
        chk("rst0", {rdy, er, rd}, 32'd0);
        sample(1, rdy, er, rd);
        chk("rst1", {rdy, er, rd}, 32'd0);

        xact("w10", 0, 1'b1, 16'h0010, 16'h00A5, 1'b0, 16'h0000);
        xact("r10", 0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00A5);
        xact("w20", 0, 1'b1, 16'h0020, 16'h0011, 1'b0, 16'h00A5);

        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0099);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 sample(0, rdy, er, rd);
        chk("midrst.out", {rdy, er, rd}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 sample(0, rdy, er, rd);
            seen |= rdy;
        end
        chk("midrst.noready", {31'b0, seen}, 32'd0);
        xact("r20", 0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0011);

        xact("w30", 0, 1'b1, 16'h0030, 16'h0033, 1'b0, 16'h0011);
        xact("r30", 0, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0033);
        xact("r1000", 0, 1'b0, 16'h1000, 16'h0000, 1'b1, 16'h0033);
        xact("rFFFF", 0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0033);
        xact("w40", 0, 1'b1, 16'h0040, 16'h0077, 1'b0, 16'h0033);
        xact("wFFF", 0, 1'b1, 16'h0FFF, 16'h005A, 1'b0, 16'h0033);
        xact("rFFF", 0, 1'b0, 16'h0FFF, 16'h0000, 1'b0, 16'h005A);
        xact("r40", 0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0077);
        xact("w1010", 0, 1'b1, 16'h1010, 16'h00EE, 1'b1, 16'h0077);
        xact("r10b", 0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00A5);

        xact("w2999", 1, 1'b1, 16'd2999, 16'h1234, 1'b0, 16'h0000);
        xact("w3000", 1, 1'b1, 16'd3000, 16'h0055, 1'b1, 16'h0000);
        xact("r2999", 1, 1'b0, 16'd2999, 16'h0000, 1'b0, 16'h1234);
        xact("r3000", 1, 1'b0, 16'd3000, 16'h0000, 1'b1, 16'h1234);

        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
        @(posedge clk);
        #1 drive(1, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h4321);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1 sample(1, rdy, er, rd);
            chk($sformatf("b2b.rdy%0d", k), {31'b0, rdy}, (k == 1 || k == 4) ? 32'd1 : 32'd0);
            if (k == 1) chk("b2b.wr_rdata", {16'b0, rd}, 32'h1234);
            if (k == 4) chk("b2b.rd_rdata", {16'b0, rd}, 32'hBEEF);
        end
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1 sample(1, rdy, er, rd);
        chk("b2b.idle", {31'b0, rdy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
